// File: rtl/score_tracker_if.sv
// Result bus into score_tracker: one match result per valid cycle.
interface score_tracker_if;
    logic       result_valid;
    logic [1:0] matchresult;

    modport master (output result_valid, output matchresult);
    modport slave  (input  result_valid, input  matchresult);
endinterface

// File: rtl/score_tracker.sv
// score_tracker: counts rounds and per-player wins of a two-player game and
// declares a winner on reaching TARGET_WINS or the MAX_ROUNDS round limit.
// Optional feature macro: SCORE_TRACKER_DRAW_COUNT_EN adds a draw counter port.
module score_tracker #(
    parameter int WIDTH       = 4,
    parameter int TARGET_WINS = 3,
    parameter int MAX_ROUNDS  = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    score_tracker_if.slave   res,
    output logic [WIDTH-1:0] round,
    output logic [WIDTH-1:0] win,
    output logic [WIDTH-1:0] lose,
`ifdef SCORE_TRACKER_DRAW_COUNT_EN
    output logic [WIDTH-1:0] draw,
`endif
    output logic             round_done,
    output logic             game_over,
    output logic [1:0]       winner
);

    typedef enum logic {PLAY, OVER} state_t;

    state_t             state;
    logic               accept;
    logic [WIDTH-1:0]   round_nx;
    logic [WIDTH-1:0]   win_nx;
    logic [WIDTH-1:0]   lose_nx;

    // Acceptance qualifier and the post-update counts used for end checks
    always_comb begin
        accept   = (state == PLAY) && res.result_valid && !clear &&
                   (res.matchresult != 2'b00);
        round_nx = round + WIDTH'(1);
        win_nx   = win  + WIDTH'(res.matchresult == 2'b10);
        lose_nx  = lose + WIDTH'(res.matchresult == 2'b11);
    end

    // Game FSM with registered counters, pulse and verdict
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= PLAY;
            round      <= '0;
            win        <= '0;
            lose       <= '0;
`ifdef SCORE_TRACKER_DRAW_COUNT_EN
            draw       <= '0;
`endif
            round_done <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
        end else if (clear) begin
            state      <= PLAY;
            round      <= '0;
            win        <= '0;
            lose       <= '0;
`ifdef SCORE_TRACKER_DRAW_COUNT_EN
            draw       <= '0;
`endif
            round_done <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
        end else begin
            round_done <= accept;
            if (accept) begin
                round <= round_nx;
                win   <= win_nx;
                lose  <= lose_nx;
`ifdef SCORE_TRACKER_DRAW_COUNT_EN
                if (res.matchresult == 2'b01)
                    draw <= draw + WIDTH'(1);
`endif
                if (win_nx == WIDTH'(TARGET_WINS)) begin
                    state     <= OVER;
                    game_over <= 1'b1;
                    winner    <= 2'b10;
                end else if (lose_nx == WIDTH'(TARGET_WINS)) begin
                    state     <= OVER;
                    game_over <= 1'b1;
                    winner    <= 2'b11;
                end else if (round_nx == WIDTH'(MAX_ROUNDS)) begin
                    state     <= OVER;
                    game_over <= 1'b1;
                    if (win_nx > lose_nx)
                        winner <= 2'b10;
                    else if (lose_nx > win_nx)
                        winner <= 2'b11;
                    else
                        winner <= 2'b01;
                end
            end
        end
    end

endmodule

// File: tb/tb_score_tracker.sv
// Scoreboard bench for score_tracker (WIDTH=4, TARGET_WINS=3, MAX_ROUNDS=5).
module tb_score_tracker;

    typedef struct {
        int         round;
        int         win;
        int         lose;
        int         draw;
        logic       go;
        logic [1:0] wn;
    } exp_t;

    logic       clk = 1'b0;
    logic       clk_run = 1'b1;
    logic       resetn;
    logic       clear;
    logic [3:0] round, win, lose;
`ifdef SCORE_TRACKER_DRAW_COUNT_EN
    logic [3:0] draw;
`endif
    logic       round_done, game_over;
    logic [1:0] winner;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];

    score_tracker_if bus();

    score_tracker #(.WIDTH(4), .TARGET_WINS(3), .MAX_ROUNDS(5)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (clear),
        .res        (bus),
        .round      (round),
        .win        (win),
        .lose       (lose),
`ifdef SCORE_TRACKER_DRAW_COUNT_EN
        .draw       (draw),
`endif
        .round_done (round_done),
        .game_over  (game_over),
        .winner     (winner)
    );

    // Clock can be held to exercise reset with no edges
    always #5 clk = clk_run ? ~clk : clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_round"}, 32'(round), 0);
        check({tag, "_win"}, 32'(win), 0);
        check({tag, "_lose"}, 32'(lose), 0);
`ifdef SCORE_TRACKER_DRAW_COUNT_EN
        check({tag, "_draw"}, 32'(draw), 0);
`endif
        check({tag, "_round_done"}, 32'(round_done), 0);
        check({tag, "_game_over"}, 32'(game_over), 0);
        check({tag, "_winner"}, 32'(winner), 0);
    endtask

    // Present one result for one cycle and queue the expected post-edge state
    task automatic send(input logic [1:0] mr, input int r, input int w, input int l,
                        input int d, input logic go, input logic [1:0] wn);
        exp_t e;
        e.round = r; e.win = w; e.lose = l; e.draw = d; e.go = go; e.wn = wn;
        bus.result_valid = 1'b1;
        bus.matchresult  = mr;
        q.push_back(e);
        @(posedge clk); #1;
        bus.result_valid = 1'b0;
    endtask

    // Present a sample that must not be accepted
    task automatic drive_ignored(input logic v, input logic [1:0] mr, input string tag);
        bus.result_valid = v;
        bus.matchresult  = mr;
        @(posedge clk); #1;
        bus.result_valid = 1'b0;
        check({tag, "_round_done"}, 32'(round_done), 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check_zero("clear");
    endtask

    // Monitor: every round_done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (round_done === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_round_done: got 1 expected 0 (round=%0d)", round);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_round", 32'(round), 32'(e.round));
                check("sb_win", 32'(win), 32'(e.win));
                check("sb_lose", 32'(lose), 32'(e.lose));
`ifdef SCORE_TRACKER_DRAW_COUNT_EN
                check("sb_draw", 32'(draw), 32'(e.draw));
`endif
                check("sb_game_over", 32'(game_over), 32'(e.go));
                check("sb_winner", 32'(winner), 32'(e.wn));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        clear  = 1'b0;
        bus.result_valid = 1'b0;
        bus.matchresult  = 2'b00;
        idle(3);
        check_zero("reset");

        // Result presented with reset release is taken at the first edge; three wins end it
        resetn = 1'b1;
        send(2'b10, 1, 1, 0, 0, 1'b0, 2'b00);
        send(2'b10, 2, 2, 0, 0, 1'b0, 2'b00);
        send(2'b10, 3, 3, 0, 0, 1'b1, 2'b10);
        drive_ignored(1'b1, 2'b11, "over_ignore");
        check("over_lose", 32'(lose), 0);
        check("over_round", 32'(round), 3);
        check("over_game_over", 32'(game_over), 1);
        check("over_winner", 32'(winner), 2);
        do_clear();

        // Round limit, player 2 ahead
        send(2'b10, 1, 1, 0, 0, 1'b0, 2'b00);
        send(2'b11, 2, 1, 1, 0, 1'b0, 2'b00);
        send(2'b01, 3, 1, 1, 1, 1'b0, 2'b00);
        send(2'b01, 4, 1, 1, 2, 1'b0, 2'b00);
        send(2'b11, 5, 1, 2, 2, 1'b1, 2'b11);
        idle(1);
        do_clear();

        // Round limit, tie
        send(2'b10, 1, 1, 0, 0, 1'b0, 2'b00);
        send(2'b11, 2, 1, 1, 0, 1'b0, 2'b00);
        send(2'b01, 3, 1, 1, 1, 1'b0, 2'b00);
        send(2'b01, 4, 1, 1, 2, 1'b0, 2'b00);
        send(2'b01, 5, 1, 1, 3, 1'b1, 2'b01);
        idle(1);
        do_clear();

        // Round limit, player 1 ahead
        send(2'b10, 1, 1, 0, 0, 1'b0, 2'b00);
        send(2'b10, 2, 2, 0, 0, 1'b0, 2'b00);
        send(2'b01, 3, 2, 0, 1, 1'b0, 2'b00);
        send(2'b01, 4, 2, 0, 2, 1'b0, 2'b00);
        send(2'b11, 5, 2, 1, 2, 1'b1, 2'b10);
        idle(1);
        do_clear();

        // Clear wins over a simultaneous result
        send(2'b10, 1, 1, 0, 0, 1'b0, 2'b00);
        send(2'b11, 2, 1, 1, 0, 1'b0, 2'b00);
        clear = 1'b1;
        bus.result_valid = 1'b1;
        bus.matchresult  = 2'b10;
        @(posedge clk); #1;
        clear = 1'b0;
        bus.result_valid = 1'b0;
        check_zero("clear_vs_valid");
        idle(1);
        check_zero("clear_vs_valid_after");

        // No-contest and invalid samples are ignored
        drive_ignored(1'b1, 2'b00, "nocontest");
        check("nocontest_round", 32'(round), 0);
        drive_ignored(1'b0, 2'b10, "notvalid");
        check("notvalid_round", 32'(round), 0);
        check("notvalid_win", 32'(win), 0);

        // Asynchronous reset mid-game with the clock held
        send(2'b10, 1, 1, 0, 0, 1'b0, 2'b00);
        send(2'b11, 2, 1, 1, 0, 1'b0, 2'b00);
        idle(1);
        clk_run = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check_zero("async_reset");
        #10;
        resetn = 1'b1;
        #1;
        check_zero("async_reset_hold");
        clk_run = 1'b1;
        @(posedge clk); #1;
        send(2'b11, 1, 0, 1, 0, 1'b0, 2'b00);
        idle(2);

        check("queue_drained", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/score_tracker.md
SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 SHALL have parameter WIDTH, default 4, bit width of every score counter.
REQ-002 SHALL have parameter TARGET_WINS, default 3, wins needed to end the game (1..2^WIDTH-1).
REQ-003 SHALL have parameter MAX_ROUNDS, default 5, round limit that ends the game (TARGET_WINS..2^WIDTH-1).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clear  input  1  synchronous restart of a game.
REQ-007 SHALL have port result_valid  input  1  matchresult is presented this cycle.
REQ-008 SHALL have port matchresult  input  2  00 no contest, 01 draw, 10 player-1 win, 11 player-2 win.
REQ-009 SHALL have port round  output  WIDTH  rounds played.
REQ-010 SHALL have port win  output  WIDTH  player-1 wins.
REQ-011 SHALL have port lose  output  WIDTH  player-2 wins.
REQ-012 SHALL have port round_done  output  1  one-cycle pulse after each accepted result.
REQ-013 SHALL have port game_over  output  1  game finished; level.
REQ-014 SHALL have port winner  output  2  00 undecided, 10 player 1, 11 player 2, 01 tie.

Function
REQ-015 SHALL implement a two-state FSM: PLAY (after reset/clear) and OVER.
REQ-016 SHALL accept a result only in PLAY with result_valid=1, clear=0 and matchresult!=00; all other samples are ignored.
REQ-017 SHALL, on an accepted result, increment round by 1 and increment win (10), lose (11) or neither (01) at the same edge; outputs are registered, one-cycle latency.
REQ-018 SHALL pulse round_done high for exactly the cycle following each accepted edge.
REQ-019 SHALL evaluate end conditions on the updated counts at the accepting edge: win==TARGET_WINS -> winner 10; else lose==TARGET_WINS -> winner 11; else round==MAX_ROUNDS -> winner by larger of win/lose, 01 if equal.
REQ-020 SHALL move to OVER and assert game_over and winner at that same edge, holding them until clear or reset.
REQ-021 SHALL keep all counters frozen in OVER; result_valid has no effect and round_done stays 0.
REQ-022 SHALL, on clear=1 in any state, zero all counters, return to PLAY, deassert game_over, set winner 00; clear takes priority over a simultaneous result_valid, which is dropped.
REQ-023 SHALL never let any counter exceed MAX_ROUNDS (no wrap-around possible within legal parameters).
REQ-024 SHALL accept back-to-back results on consecutive cycles without loss.

Reset
REQ-025 SHALL, while resetn=0, asynchronously force round, win, lose, draw = 0, round_done = 0, game_over = 0, winner = 00, state PLAY, independent of clk.
REQ-026 SHALL resume normal operation at the first rising clk edge after resetn rises; a result sampled at that edge is accepted.

Configuration
REQ-027 SHALL, with SCORE_TRACKER_DRAW_COUNT_EN defined, add port draw  output  WIDTH, incremented on each accepted 01 result, cleared by clear/reset, frozen in OVER.
REQ-028 SHALL, without SCORE_TRACKER_DRAW_COUNT_EN, have no draw port and no draw register; all other behaviour identical.

Verification (WIDTH=4, TARGET_WINS=3, MAX_ROUNDS=5)
REQ-029 SHALL cover: resetn low mid-game with no clock toggling -> all outputs 0, winner 00 immediately.
REQ-030 SHALL cover: 10,10,10 valid on consecutive cycles -> win=3, round=3, game_over=1, winner=10 after third edge; following 11 ignored, lose stays 0.
REQ-031 SHALL cover: 10,11,01,01,11 -> round=5, win=1, lose=2, game_over=1, winner=11; draw=2 when macro defined.
REQ-032 SHALL cover: 10,11,01,01,01 -> round=5, win=1, lose=1, winner=01 (tie).
REQ-033 SHALL cover: clear and result_valid (10) in the same cycle mid-game -> all counters 0, round_done 0, game_over 0.
REQ-034 SHALL cover: result_valid with matchresult 00, then result_valid low with matchresult 10 -> no counter change, round_done stays 0.
